// File: rtl/sr_latch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : sr_latch_arbiter
//  Purpose  : Shares one cross-coupled NAND SR latch between N_REQ requesters.
//             Set/clear requests are served round-robin. Each transaction
//             drives a timed active-low pulse on Sbar or Rbar (never both),
//             reads back Q, flags a sticky fault on a mismatch and issues a
//             one-cycle ack to the granted requester.
//  Revision : 1.0 - initial release
// ============================================================================
module sr_latch_arbiter #(
    parameter int N_REQ        = 4,   // number of requesters (2..8)
    parameter int PULSE_CYCLES = 2,   // low-pulse width on Sbar/Rbar (>=1)
    parameter int GAP_CYCLES   = 1,   // idle clocks after each transaction (>=1)
    parameter int IDX_W        = 2    // clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] op,
    output logic [N_REQ-1:0] ack,
    output logic             sbar,
    output logic             rbar,
    input  logic             q_in,
    output logic             busy,
    output logic [IDX_W-1:0] grant_idx,
    output logic             fault
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // One shared down-counter times both the pulse and the gap; it only ever
    // holds (cycles - 1), so clog2 of the larger count is wide enough.
    localparam int c_cnt_max = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int c_cnt_w   = (c_cnt_max > 1) ? $clog2(c_cnt_max) : 1;
    // Candidate index arithmetic needs one spare bit so ptr + offset never
    // wraps before the explicit modulo-N_REQ correction.
    localparam int c_pos_w   = IDX_W + 1;

    localparam logic [c_cnt_w-1:0] c_pulse_load = c_cnt_w'(PULSE_CYCLES - 1);
    localparam logic [c_cnt_w-1:0] c_gap_load   = c_cnt_w'(GAP_CYCLES - 1);
    localparam logic [c_pos_w-1:0] c_n_req      = c_pos_w'(N_REQ);
    localparam logic [IDX_W-1:0]   c_last_idx   = IDX_W'(N_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PULSE = 2'd1,
        S_CHECK = 2'd2,
        S_GAP   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t             r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [IDX_W-1:0]   r_ptr;     // round-robin search start
    logic [IDX_W-1:0]   r_grant;   // current / last granted requester
    logic               r_cmd;     // op captured at grant: 1 = set, 0 = clear
    logic               r_sbar;
    logic               r_rbar;
    logic [N_REQ-1:0]   r_ack;
    logic               r_fault;

    // ------------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------------
    state_t             w_state_nxt;
    logic [c_cnt_w-1:0] w_cnt_nxt;
    logic [IDX_W-1:0]   w_ptr_nxt;
    logic [IDX_W-1:0]   w_grant_nxt;
    logic               w_cmd_nxt;
    logic               w_sbar_nxt;
    logic               w_rbar_nxt;
    logic [N_REQ-1:0]   w_ack_nxt;
    logic               w_fault_nxt;

    // Arbiter results
    logic               w_found;
    logic [IDX_W-1:0]   w_sel_idx;
    logic [c_pos_w-1:0] w_pos;
    logic [IDX_W-1:0]   w_cand;
    logic               w_sel_op;
    logic [IDX_W-1:0]   w_sel_inc;

    // Round-robin search: first requester at or above r_ptr, wrapping to 0.
    always_comb begin
        w_found   = 1'b0;
        w_sel_idx = '0;
        w_pos     = '0;
        w_cand    = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_pos = {1'b0, r_ptr} + c_pos_w'(i);
            if (w_pos >= c_n_req) begin
                w_pos = w_pos - c_n_req;
            end
            w_cand = w_pos[IDX_W-1:0];
            if (!w_found && req[w_cand]) begin
                w_found   = 1'b1;
                w_sel_idx = w_cand;
            end
        end
    end

    // Command of the selected requester and the pointer value after it.
    always_comb begin
        w_sel_op  = op[w_sel_idx];
        w_sel_inc = (w_sel_idx == c_last_idx) ? '0 : (w_sel_idx + 1'b1);
    end

    // Next-state and output logic; lines default high so only an explicit
    // PULSE assignment can pull one low, and never both at once.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        w_cmd_nxt   = r_cmd;
        w_sbar_nxt  = 1'b1;
        w_rbar_nxt  = 1'b1;
        w_ack_nxt   = '0;
        w_fault_nxt = r_fault;

        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant_nxt = w_sel_idx;
                    w_cmd_nxt   = w_sel_op;
                    w_ptr_nxt   = w_sel_inc;
                    if (q_in == w_sel_op) begin
                        // Latch already holds the requested value: no pulse.
                        w_state_nxt = S_CHECK;
                    end else begin
                        w_state_nxt = S_PULSE;
                        w_cnt_nxt   = c_pulse_load;
                        w_sbar_nxt  = ~w_sel_op;
                        w_rbar_nxt  = w_sel_op;
                    end
                end
            end

            S_PULSE: begin
                if (r_cnt == '0) begin
                    // Both lines return high on this edge.
                    w_state_nxt = S_CHECK;
                end else begin
                    w_cnt_nxt  = r_cnt - 1'b1;
                    w_sbar_nxt = ~r_cmd;
                    w_rbar_nxt = r_cmd;
                end
            end

            S_CHECK: begin
                if (q_in != r_cmd) begin
                    w_fault_nxt = 1'b1;
                end
                w_ack_nxt   = N_REQ'(1) << r_grant;
                w_state_nxt = S_GAP;
                w_cnt_nxt   = c_gap_load;
            end

            S_GAP: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register; reset aborts any pulse and discards the pending grant.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ptr   <= '0;
            r_grant <= '0;
            r_cmd   <= 1'b0;
            r_sbar  <= 1'b1;
            r_rbar  <= 1'b1;
            r_ack   <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            r_cmd   <= w_cmd_nxt;
            r_sbar  <= w_sbar_nxt;
            r_rbar  <= w_rbar_nxt;
            r_ack   <= w_ack_nxt;
            r_fault <= w_fault_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign sbar      = r_sbar;
    assign rbar      = r_rbar;
    assign ack       = r_ack;
    assign grant_idx = r_grant;
    assign fault     = r_fault;
    assign busy      = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sr_latch_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_latch_arbiter
//  Purpose  : Self-checking bench for sr_latch_arbiter with a clocked NAND
//             latch model and an ack scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sr_latch_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [N-1:0] req;
    logic [N-1:0] op;
    logic [N-1:0] ack;
    logic         sbar;
    logic         rbar;
    logic         q_in;
    logic         busy;
    logic [1:0]   grant_idx;
    logic         fault;

    // Latch model controls
    logic q_model    = 1'b0;
    logic stuck      = 1'b0;
    logic q_load     = 1'b0;
    logic q_load_val = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [N-1:0] ack;
        logic [1:0]   idx;
        logic         fault;
    } exp_t;

    exp_t sb_q[$];

    sr_latch_arbiter #(
        .N_REQ       (N),
        .PULSE_CYCLES(2),
        .GAP_CYCLES  (1),
        .IDX_W       (2)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .op       (op),
        .ack      (ack),
        .sbar     (sbar),
        .rbar     (rbar),
        .q_in     (q_in),
        .busy     (busy),
        .grant_idx(grant_idx),
        .fault    (fault)
    );

    always #5 clk = ~clk;

    assign q_in = q_model;

    // NAND SR latch seen through a synchroniser: follows the active-low lines.
    always @(posedge clk) begin
        if (q_load) begin
            q_model <= q_load_val;
        end else if (!stuck) begin
            if (!sbar && rbar)
                q_model <= 1'b1;
            else if (sbar && !rbar)
                q_model <= 1'b0;
        end
    end

    // Monitor: invariant on the latch lines and ack scoreboard compare.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            n_checks++;
            if (!sbar && !rbar) begin
                n_errors++;
                $display("FAIL sbar_rbar_both_low: sbar=%b rbar=%b required not both 0", sbar, rbar);
            end
            if (ack != '0) begin
                n_checks++;
                if (sb_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_ack: ack=%b grant=%0d required no ack", ack, grant_idx);
                end else begin
                    e = sb_q.pop_front();
                    if (ack !== e.ack || grant_idx !== e.idx || fault !== e.fault) begin
                        n_errors++;
                        $display("FAIL ack_scoreboard: ack=%b idx=%0d fault=%b required ack=%b idx=%0d fault=%b",
                                 ack, grant_idx, fault, e.ack, e.idx, e.fault);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [N-1:0] a, input logic [1:0] i, input logic f);
        exp_t e;
        e.ack   = a;
        e.idx   = i;
        e.fault = f;
        sb_q.push_back(e);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        repeat (3) tick();
        reset = 1'b0;
    endtask

    task automatic load_q(input logic v);
        q_load     = 1'b1;
        q_load_val = v;
        tick();
        q_load     = 1'b0;
    endtask

    // Requesters drop their line in the cycle ack is seen; wait for idle.
    task automatic serve(input int bound);
        for (int n = 0; n < bound; n++) begin
            tick();
            req = req & ~ack;
            if (req == '0 && !busy) return;
        end
        n_checks++;
        n_errors++;
        $display("FAIL serve_timeout: req=%b busy=%b required idle within %0d cycles", req, busy, bound);
        req = '0;
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic exp_sbar [5];
        logic exp_busy [5];
        logic [N-1:0] exp_ack [5];

        reset = 1'b1;
        req   = '0;
        op    = '0;

        // ---------------- Test 1: reset, held idle ----------------
        do_reset();
        for (int k = 0; k < 10; k++) begin
            tick();
            chk("reset_idle", {sbar, rbar, ack, busy, fault, grant_idx},
                {1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0});
        end

        // ---------------- Test 2: set with pulse timing ----------------
        load_q(1'b0);
        exp_sbar = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_ack  = '{4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000};
        push_exp(4'b0001, 2'd0, 1'b0);
        op  = 4'b0001;
        req = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk($sformatf("set_timing_t%0d", k + 1), {sbar, rbar, busy, ack},
                {exp_sbar[k], 1'b1, exp_busy[k], exp_ack[k]});
            req = req & ~ack;
        end
        req = '0;
        chk("set_q_result", {q_model, fault}, {1'b1, 1'b0});

        // ---------------- Test 3: round-robin ----------------
        do_reset();
        op = 4'b0101;
        push_exp(4'b0001, 2'd0, 1'b0);
        push_exp(4'b0010, 2'd1, 1'b0);
        push_exp(4'b0100, 2'd2, 1'b0);
        push_exp(4'b1000, 2'd3, 1'b0);
        req = 4'b1111;
        serve(200);
        chk("rr_all_acked", sb_q.size(), 0);
        chk("rr_q_after_clear", q_model, 1'b0);
        // Grant 0 once more so the pointer sits at 1.
        op  = 4'b0001;
        push_exp(4'b0001, 2'd0, 1'b0);
        req = 4'b0001;
        serve(50);
        op  = 4'b0000;
        push_exp(4'b0100, 2'd2, 1'b0);
        push_exp(4'b0001, 2'd0, 1'b0);
        req = 4'b0101;
        serve(100);
        chk("rr_ptr1_order_done", sb_q.size(), 0);
        chk("rr_q_final", q_model, 1'b0);

        // ---------------- Test 4: skip, latch already set ----------------
        load_q(1'b1);
        exp_busy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        exp_ack  = '{4'b0000, 4'b0001, 4'b0000, 4'b0000, 4'b0000};
        push_exp(4'b0001, 2'd0, 1'b0);
        op  = 4'b0001;
        req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk($sformatf("skip_t%0d", k + 1), {sbar, rbar, busy, ack},
                {1'b1, 1'b1, exp_busy[k], exp_ack[k]});
            req = req & ~ack;
        end
        req = '0;

        // ---------------- Test 5: stuck latch, sticky fault ----------------
        stuck = 1'b1;
        load_q(1'b0);
        op = 4'b0010;
        push_exp(4'b0010, 2'd1, 1'b1);
        req = 4'b0010;
        serve(50);
        chk("stuck_fault_set", fault, 1'b1);
        stuck = 1'b0;
        op = 4'b0100;
        push_exp(4'b0100, 2'd2, 1'b1);
        req = 4'b0100;
        serve(50);
        chk("fault_sticky_after_set", {fault, q_model}, {1'b1, 1'b1});
        op = 4'b0000;
        push_exp(4'b1000, 2'd3, 1'b1);
        req = 4'b1000;
        serve(50);
        chk("fault_sticky_after_clear", {fault, q_model}, {1'b1, 1'b0});

        // ---------------- Test 6: reset during pulse ----------------
        do_reset();
        chk("fault_cleared_by_reset", fault, 1'b0);
        load_q(1'b0);
        op  = 4'b0001;
        req = 4'b0001;
        tick();
        chk("abort_pulse_c1", {sbar, rbar}, {1'b0, 1'b1});
        tick();
        chk("abort_pulse_c2", {sbar, rbar}, {1'b0, 1'b1});
        reset = 1'b1;
        req   = '0;
        tick();
        chk("abort_after_reset", {sbar, rbar, ack, busy, grant_idx},
            {1'b1, 1'b1, 4'b0000, 1'b0, 2'd0});
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            chk("abort_no_ack", {ack, busy}, {4'b0000, 1'b0});
        end
        // Pointer back at 0: requester 0 before 3.
        op = 4'b1000;
        push_exp(4'b0001, 2'd0, 1'b0);
        push_exp(4'b1000, 2'd3, 1'b0);
        req = 4'b1001;
        serve(100);
        chk("post_abort_queue_empty", sb_q.size(), 0);
        chk("post_abort_q", {q_model, fault}, {1'b1, 1'b0});

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
